ldm_sequencer: RTL
==================

Name: ldm_sequencer

Overview:
- Sits between the IF/ID boundary and the decode stage of the combined ARM/RISC-V core. It replaces the plain IF/ID instruction register.
- It expands each ARM block transfer (LDM/STM) into a stream of single-register LDR/STR micro-ops plus an optional base-writeback ADD/SUB. Decode and the immediate extender then see only simple 8/12-bit immediate forms.
- All other instructions, and everything in RISC-V mode, pass through with one cycle of latency.

Parameters:
- NREGS, 16, size of the ARM register list (bits [15:0]).
- WORD_BYTES, 4, byte stride per transferred register.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- armD  in  1  1 = ARM mode, 0 = RISC-V mode (pass-through only).
- instr_i  in  32  instruction from fetch.
- valid_i  in  1  instr_i valid.
- ready_o  out  1  sequencer accepts instr_i this cycle; fetch stalls when low.
- stall_i  in  1  decode stall from the hazard unit; hold all state.
- flush_i  in  1  decode flush; abort any sequence.
- instr_o  out  32  registered instruction to decode (instrD).
- valid_o  out  1  instr_o valid.
- uop_o  out  1  instr_o is a synthesized micro-op.
- last_o  out  1  instr_o is the final op of its macro-instruction (1 for pass-through).
- busy_o  out  1  a sequence is in progress (state != IDLE).

Behaviour:
- Reset values: instr_o=0, valid_o=0, uop_o=0, last_o=0, busy_o=0, state=IDLE, remaining-list=0, k=0.
- LDM/STM is detected when armD=1 and instr_i[27:25]=3'b100. Field map: cond=[31:28], P=[24], U=[23], S=[22] (ignored; no user-bank support), W=[21], L=[20], Rn=[19:16], list=[15:0].
- ready_o = (state==IDLE) && !stall_i && !flush_i.
- Pass-through: on accept, instr_o<=instr_i, valid_o<=1, uop_o<=0, last_o<=1.
- On accepting an LDM/STM, latch cond, P, U, W, L, Rn, list and n=popcount(list). Emit micro-op k=0 in the same registered update.
- Registers are emitted lowest-numbered first. Byte offset of micro-op k relative to Rn:
  - IA: 4k
  - IB: 4k+4
  - DA: 4k-4n+4
  - DB: 4k-4n
- Transfer micro-op encoding = {cond, 2'b01, I=0, P=1, u, B=0, W=0, L, Rn, Rd, imm12}.
  - u = (offset >= 0); imm12 = |offset|.
  - Offset arithmetic is signed 8-bit (range -64..+64).
- Writeback micro-op is emitted after the last transfer iff W=1, and not (L=1 and Rn is in list), in which case it is suppressed. Encoding = {cond, 3'b001, op, S=0, Rn, Rn, 4'b0000, imm8=4n}, with op=4'b0100 (ADD) if U else 4'b0010 (SUB).
- Empty list: emit a single NOP {cond, 28'h1A00000} with uop_o=1, last_o=1.
- States:
  - IDLE: accept input.
  - XFER: emit the next set bit, clear it; go to WB when the list empties and writeback is required, else to IDLE.
  - WB: emit writeback, go to IDLE.
  - The state moves to IDLE in the same cycle the last micro-op is registered, so the next instruction is accepted with no bubble.
- stall_i=1: all registers hold, and ready_o=0.
- flush_i=1 (priority over stall_i): valid_o<=0, state<=IDLE, list cleared, input not accepted.
- valid_i=0 in IDLE: valid_o<=0, and instr_o holds.
- Reset asserted mid-sequence returns to the reset values immediately.

Optional Feature:
- LDM_WRITEBACK_EN
  - Defined: writeback micro-op generated as above.
  - Undefined: W bit ignored, WB state absent, and the last transfer carries last_o=1.

Decomposition:
- Package ldm_pkg holds:
  - state enum {IDLE, XFER, WB};
  - localparams for the LDST/DP field positions;
  - ADD/SUB opcodes;
  - the NOP constant.
- Sub-module lowest_set: 16-bit find-first-set (4-bit index plus found flag) and 5-bit popcount, purely combinational.

Test Plan:
- 0xE8B00026 (LDMIA R0!,{R1,R2,R5}) -> instr_o 0xE5901000, 0xE5902004, 0xE5905008, 0xE280000C on four consecutive cycles; last_o only on the fourth; ready_o low for three cycles.
- 0xE92D4010 (STMDB SP!,{R4,LR}) -> 0xE50D4008, 0xE50DE004, 0xE24DD008.
- Back-to-back: 0xE8900003 (LDMIA R0,{R0,R1}, no W) followed by RISC-V 0x00500093 with armD=0 -> 0xE5900000, 0xE5901004, then 0x00500093 the next cycle with no bubble.
- stall_i held for 2 cycles mid-sequence -> instr_o frozen and no micro-op skipped or duplicated.
- flush_i during the second micro-op of a 4-register LDM -> valid_o=0 the next cycle, busy_o=0, ready_o=1.
- Empty list 0xE8900000 -> single NOP 0xE1A00000 with uop_o=1, last_o=1. Reset asserted mid-sequence -> all outputs 0.

Source files
------------

// File: rtl/ldm_pkg.sv
// Shared definitions for the LDM/STM micro-op sequencer: state encoding,
// instruction field positions, data-processing opcodes and micro-op builders.
package ldm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } ldm_state_e;

  // Plain-vector copies of the states for the legacy-style state register
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_XFER = XFER;
  localparam logic [1:0] ST_WB   = WB;

  // Block-transfer field positions
  localparam int F_COND_LO = 28;
  localparam int F_CLS_HI  = 27;
  localparam int F_CLS_LO  = 25;
  localparam int F_P       = 24;
  localparam int F_U       = 23;
  localparam int F_S       = 22;
  localparam int F_W       = 21;
  localparam int F_L       = 20;
  localparam int F_RN_LO   = 16;

  localparam logic [2:0]  LDM_CLASS    = 3'b100;
  localparam logic [1:0]  LDST_CLASS   = 2'b01;
  localparam logic [2:0]  DP_IMM_CLASS = 3'b001;
  localparam logic [3:0]  OP_ADD       = 4'b0100;
  localparam logic [3:0]  OP_SUB       = 4'b0010;
  localparam logic [27:0] NOP_BODY     = 28'h1A00000;

  // Single-register LDR/STR, pre-indexed immediate, no writeback
  function automatic logic [31:0] ldst_uop(input logic [3:0] cond, input logic up,
                                           input logic load, input logic [3:0] rn,
                                           input logic [3:0] rd, input logic [7:0] mag);
    return {cond, LDST_CLASS, 1'b0, 1'b1, up, 1'b0, 1'b0, load, rn, rd, 4'b0000, mag};
  endfunction

  // Base writeback: ADD/SUB Rn, Rn, #imm8
  function automatic logic [31:0] dp_uop(input logic [3:0] cond, input logic add,
                                         input logic [3:0] rn, input logic [7:0] imm8);
    return {cond, DP_IMM_CLASS, (add ? OP_ADD : OP_SUB), 1'b0, rn, rn, 4'b0000, imm8};
  endfunction

endpackage

// File: rtl/lowest_set.sv
// Combinational find-first-set (lowest index) and population count over a
// 16-bit register list.
module lowest_set (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        found_o,
  output logic [4:0]  count_o
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx_o   = 4'd0;
    found_o = 1'b0;
    count_o = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = 4'(i);
        found_o = 1'b1;
      end
      count_o = count_o + 5'(vec_i[i]);
    end
  end

endmodule

// File: rtl/ldm_sequencer.sv
// IF/ID instruction register that expands ARM LDM/STM into single-register
// LDR/STR micro-ops (lowest register first) and passes everything else
// through with one cycle of latency.
// Optional macro LDM_WRITEBACK_EN: when defined, W=1 adds a trailing base
// ADD/SUB micro-op; when undefined the W bit is ignored.
module ldm_sequencer
  import ldm_pkg::*;
#(
  parameter int NREGS      = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        armD,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        uop_o,
  output logic        last_o,
  output logic        busy_o
);

  logic [1:0]       state_q, state_d;
  logic [NREGS-1:0] list_q, list_d;
  logic [4:0]       k_q, k_d, n_q, n_d;
  logic [3:0]       cond_q, cond_d, rn_q, rn_d;
  logic             p_q, p_d, u_q, u_d, l_q, l_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d, uop_q, uop_d, last_q, last_d;
`ifdef LDM_WRITEBACK_EN
  logic             wb_q, wb_d;
`endif

  logic             idle, is_ldm, do_xfer;
  logic [3:0]       cur_cond, cur_rn, first_idx;
  logic             cur_p, cur_u, cur_l, cur_wb, first_found;
  logic [NREGS-1:0] src_list, rest_list;
  logic [4:0]       cur_n, cur_k, list_count;
  logic [7:0]       k_bytes, n_bytes, stride, off, mag;
  logic [31:0]      xfer_instr;

  // S bit has no effect (no user-bank support); W is only used with writeback
  logic unused_bits;
  assign unused_bits = ^{instr_i[F_S], instr_i[F_W]};

  assign idle     = (state_q == ST_IDLE);
  assign is_ldm   = armD && (instr_i[F_CLS_HI:F_CLS_LO] == LDM_CLASS);
  assign ready_o  = idle && !stall_i && !flush_i;
  assign busy_o   = !idle;

  // In IDLE the fields come straight from the incoming instruction so the
  // first micro-op is produced in the accepting cycle.
  assign cur_cond = idle ? instr_i[31:F_COND_LO]         : cond_q;
  assign cur_p    = idle ? instr_i[F_P]                  : p_q;
  assign cur_u    = idle ? instr_i[F_U]                  : u_q;
  assign cur_l    = idle ? instr_i[F_L]                  : l_q;
  assign cur_rn   = idle ? instr_i[F_RN_LO+3:F_RN_LO]    : rn_q;
  assign src_list = idle ? instr_i[NREGS-1:0]            : list_q;
  assign cur_n    = idle ? list_count                    : n_q;
  assign cur_k    = idle ? 5'd0                          : k_q;

  lowest_set u_find (
    .vec_i   (src_list),
    .idx_o   (first_idx),
    .found_o (first_found),
    .count_o (list_count)
  );

  assign rest_list = src_list & ~(NREGS'(1) << first_idx);
  assign stride    = 8'(WORD_BYTES);
  assign k_bytes   = stride * {3'b000, cur_k};
  assign n_bytes   = stride * {3'b000, cur_n};

`ifdef LDM_WRITEBACK_EN
  // Loading the base register makes the loaded value win over writeback
  assign cur_wb = idle ? (instr_i[F_W] && !(instr_i[F_L] && instr_i[instr_i[F_RN_LO+3:F_RN_LO]]))
                       : wb_q;
`else
  assign cur_wb = 1'b0;
`endif

  // Signed 8-bit byte offset of micro-op k for the four addressing modes
  always_comb begin
    case ({cur_p, cur_u})
      2'b01:   off = k_bytes;                     // IA
      2'b11:   off = k_bytes + stride;            // IB
      2'b00:   off = k_bytes - n_bytes + stride;  // DA
      default: off = k_bytes - n_bytes;           // DB
    endcase
  end

  assign mag        = off[7] ? (8'd0 - off) : off;
  assign xfer_instr = ldst_uop(cur_cond, ~off[7], cur_l, cur_rn, first_idx, mag);

  // Next-state: flush beats stall, stall freezes everything
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    k_d     = k_q;
    n_d     = n_q;
    cond_d  = cond_q;
    rn_d    = rn_q;
    p_d     = p_q;
    u_d     = u_q;
    l_d     = l_q;
    instr_d = instr_q;
    valid_d = valid_q;
    uop_d   = uop_q;
    last_d  = last_q;
`ifdef LDM_WRITEBACK_EN
    wb_d    = wb_q;
`endif
    do_xfer = 1'b0;

    if (flush_i) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
      list_d  = '0;
      k_d     = 5'd0;
    end else if (!stall_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!valid_i) begin
            valid_d = 1'b0;
          end else if (is_ldm) begin
            cond_d = cur_cond;
            rn_d   = cur_rn;
            p_d    = cur_p;
            u_d    = cur_u;
            l_d    = cur_l;
            n_d    = list_count;
`ifdef LDM_WRITEBACK_EN
            wb_d   = cur_wb;
`endif
            if (!first_found) begin
              instr_d = {cur_cond, NOP_BODY};
              valid_d = 1'b1;
              uop_d   = 1'b1;
              last_d  = 1'b1;
            end else begin
              do_xfer = 1'b1;
            end
          end else begin
            instr_d = instr_i;
            valid_d = 1'b1;
            uop_d   = 1'b0;
            last_d  = 1'b1;
          end
        end
        ST_XFER: do_xfer = 1'b1;
`ifdef LDM_WRITEBACK_EN
        ST_WB: begin
          instr_d = dp_uop(cond_q, u_q, rn_q, n_bytes);
          valid_d = 1'b1;
          uop_d   = 1'b1;
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase

      if (do_xfer) begin
        instr_d = xfer_instr;
        valid_d = 1'b1;
        uop_d   = 1'b1;
        list_d  = rest_list;
        k_d     = cur_k + 5'd1;
        if (rest_list == '0) begin
          last_d  = !cur_wb;
          state_d = cur_wb ? ST_WB : ST_IDLE;
        end else begin
          last_d  = 1'b0;
          state_d = ST_XFER;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      k_q     <= 5'd0;
      n_q     <= 5'd0;
      cond_q  <= 4'd0;
      rn_q    <= 4'd0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      l_q     <= 1'b0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      uop_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef LDM_WRITEBACK_EN
      wb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      k_q     <= k_d;
      n_q     <= n_d;
      cond_q  <= cond_d;
      rn_q    <= rn_d;
      p_q     <= p_d;
      u_q     <= u_d;
      l_q     <= l_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      uop_q   <= uop_d;
      last_q  <= last_d;
`ifdef LDM_WRITEBACK_EN
      wb_q    <= wb_d;
`endif
    end
  end

  assign instr_o = instr_q;
  assign valid_o = valid_q;
  assign uop_o   = uop_q;
  assign last_o  = last_q;

endmodule
